pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 125 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
`default_nettype none
//==============================================================================
// Module      : pipe_skid_reg
// Description : One-stage valid/ready pipeline register with optional skid
//               buffer. An entry accepted into an empty stage is presented on
//               the output on the following cycle. out_data carries NOP_VAL
//               whenever out_valid is low.
//
//               Build option (macro PIPE_SKID_EN):
//                 defined   - two registers (main + skid). in_ready is a pure
//                             function of state (!skid_valid), which breaks
//                             the combinational out_ready -> in_ready path.
//                 undefined - main register only. in_ready =
//                             out_ready | !out_valid (combinational).
//
// Parameters  : DATA_W     payload width in bits
//               NOP_VAL    bubble payload driven while out_valid = 0
//
// Ports       : clk        rising-edge clock
//               rst        asynchronous, active-low reset
//               flush      drop every held entry (and any same-cycle accept)
//               in_valid   upstream entry present
//               in_ready   stage accepts an entry this cycle
//               in_data    upstream payload
//               out_valid  downstream entry present
//               out_ready  downstream consumes the entry this cycle
//               out_data   downstream payload (NOP_VAL when not valid)
//               occupancy  number of held entries, 0..2
//
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_skid_reg #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              w_accept;
    logic              w_consume;

    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_main_valid & out_ready;

`ifdef PIPE_SKID_EN
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;

    // The skid register is only ever filled while main is full, so
    // !skid_valid is exactly "there is room for one more entry". Gating with
    // rst keeps in_ready low for the whole reset interval.
    assign in_ready = rst & ~r_skid_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= NOP_VAL;
            r_skid_valid <= 1'b0;
            r_skid_data  <= NOP_VAL;
        end else if (flush) begin
            // Same-cycle accept and consume are both discarded.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid) begin
            // Empty stage: skid is necessarily empty as well.
            if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_data  <= in_data;
            end
        end else if (w_consume) begin
            if (r_skid_valid) begin
                // in_ready was low, so no accept can coincide with this move.
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main_data  <= in_data;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Main is full and stalled: park the new entry in skid.
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
        end
    end

    assign occupancy = {r_main_valid & r_skid_valid, r_main_valid ^ r_skid_valid};
`else
    // Single register: room exists when empty or when the held entry leaves
    // in this same cycle.
    assign in_ready = rst & (out_ready | ~r_main_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= NOP_VAL;
        end else if (flush) begin
            r_main_valid <= 1'b0;
        end else if (w_accept) begin
            r_main_valid <= 1'b1;
            r_main_data  <= in_data;
        end else if (w_consume) begin
            r_main_valid <= 1'b0;
        end
    end

    assign occupancy = {1'b0, r_main_valid};
`endif

    assign out_valid = r_main_valid;
    assign out_data  = r_main_valid ? r_main_data : NOP_VAL;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
//==============================================================================
// Module      : tb_pipe_skid_reg
// Description : Self-checking bench for pipe_skid_reg. A queue-based model
//               of the stage (capacity 2 with PIPE_SKID_EN, else 1) is
//               compared against the DUT on every falling edge; directed
//               sequences pin literal values; a long randomized run follows.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pipe_skid_reg;

    localparam int           DW  = 8;
    localparam logic [DW-1:0] NOP = 8'hC3;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] q[$];
    logic          m_acc;
    logic          m_cons;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(DW), .NOP_VAL(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: room is "fewer than capacity entries", or, without skid, also
    // "the single held entry is leaving now".
    function automatic logic m_in_ready();
        if (!rst) return 1'b0;
        if (SKID) return q.size() < 2;
        return out_ready || (q.size() == 0);
    endfunction

    function automatic logic [DW-1:0] m_out_data();
        if (q.size() == 0) return NOP;
        return q[0];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            m_acc  = in_valid && m_in_ready();
            m_cons = (q.size() > 0) && out_ready;
            if (m_cons) void'(q.pop_front());
            if (m_acc)  q.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("out_data",  {24'd0, out_data},  {24'd0, m_out_data()});
        chk("in_ready",  {31'd0, in_ready},  {31'd0, m_in_ready()});
        chk("occupancy", {30'd0, occupancy}, q.size());
        chk("occ_le_2",  {31'd0, occupancy <= 2'd2}, 32'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input logic v, input logic [DW-1:0] d,
                             input logic [1:0] occ, input logic rdy);
        chk({name, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({name, ".data"},  {24'd0, out_data},  {24'd0, d});
        chk({name, ".occ"},   {30'd0, occupancy}, {30'd0, occ});
        chk({name, ".rdy"},   {31'd0, in_ready},  {31'd0, rdy});
    endtask

    int pv;
    int pr;

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        chk_state("reset_noclk", 1'b0, NOP, 2'd0, 1'b0);
        tick();
        tick();
        chk_state("reset_held", 1'b0, NOP, 2'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("release_rdy", {31'd0, in_ready}, 32'd1);

        // Streaming
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 8'h11; tick(); chk_state("stream0", 1'b1, 8'h11, 2'd1, 1'b1);
        in_data = 8'h22; tick(); chk_state("stream1", 1'b1, 8'h22, 2'd1, 1'b1);
        in_data = 8'h33; tick(); chk_state("stream2", 1'b1, 8'h33, 2'd1, 1'b1);
        in_valid = 1'b0; tick(); chk_state("stream_end", 1'b0, NOP, 2'd0, 1'b1);

`ifdef PIPE_SKID_EN
        // Skid: second entry parks while the output stalls
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hA0; tick(); chk_state("skid0", 1'b1, 8'hA0, 2'd1, 1'b1);
        in_data = 8'hA1; tick(); chk_state("skid1", 1'b1, 8'hA0, 2'd2, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        #1; chk("skid_rdy_nocomb", {31'd0, in_ready}, 32'd0);
        tick(); chk_state("skid2", 1'b1, 8'hA1, 2'd1, 1'b1);
        tick(); chk_state("skid3", 1'b0, NOP, 2'd0, 1'b1);
`else
        // Single register: combinational in_ready from out_ready
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
        tick(); chk_state("pass0", 1'b1, 8'h3C, 2'd1, 1'b0);
        in_data = 8'h5A;
        #1; chk("pass_rdy_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1; chk("pass_rdy_comb", {31'd0, in_ready}, 32'd1);
        tick(); chk_state("pass1", 1'b1, 8'h5A, 2'd1, 1'b1);
        in_valid = 1'b0;
        tick(); chk_state("pass2", 1'b0, NOP, 2'd0, 1'b1);
`endif

        // Flush from full
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h44; tick();
        in_data = 8'h55; tick();
        chk("flush_full", {30'd0, occupancy}, SKID ? 32'd2 : 32'd1);
        flush = 1'b1; in_data = 8'hFF;
        tick(); chk_state("flush0", 1'b0, NOP, 2'd0, 1'b1);
        // Flush while in_ready is high: the offered entry is dropped
        tick(); chk_state("flush1", 1'b0, NOP, 2'd0, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); chk_state("flush2", 1'b0, NOP, 2'd0, 1'b1);

        // Asynchronous reset mid-operation
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        tick(); in_valid = 1'b0;
        chk("areset_pre", {30'd0, occupancy}, 32'd1);
        #3; rst = 1'b0;
        #1; chk_state("areset", 1'b0, NOP, 2'd0, 1'b0);
        @(posedge clk); #2; rst = 1'b1;
        #1; chk_state("areset_rel", 1'b0, NOP, 2'd0, 1'b1);

        // Randomized valid/ready with occasional flush
        for (int i = 0; i < 10000; i++) begin
            if (i % 1000 == 0) begin
                pv = $urandom_range(10, 95);
                pr = $urandom_range(10, 95);
            end
            in_valid  = ($urandom_range(0, 99) < pv);
            out_ready = ($urandom_range(0, 99) < pr);
            flush     = ($urandom_range(0, 199) == 0);
            in_data   = DW'($urandom);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        chk_state("drain", 1'b0, NOP, 2'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
